wb_irq_debounce_ctrl: RTL and testbench

Parametrised Wishbone interrupt-conditioning slave that replaces the fixed three-channel debounce-and-concatenate interrupt path in the FPGA top level. Synchronises and debounces `NUM_CH` external interrupt inputs, applies per-channel level/edge mode and enable masking, latches pending events, and drives one combined interrupt request to the CPU. It sits on an intercon slave port and exposes a five-register map for software control.

---
 rtl/wb_irq_debounce_ctrl.sv | 142 ++++++++++++++
 tb/tb_wb_irq_debounce_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_irq_debounce_ctrl.sv
// Wishbone interrupt conditioner: per-channel sync + debounce, level/edge
// pending latches with enable masking, and one registered combined request.

module wb_irq_debounce_lane #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          flip;

  // flip is the edge on which the counter would reach DB_CYCLES
  assign flip = (sync[1] != clean) && (cnt == CW'(DB_CYCLES - 1));
  assign rise = flip && !clean;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == clean) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        clean <= ~clean;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module wb_irq_debounce_ctrl #(
  parameter int NUM_CH    = 8,
  parameter int DB_CYCLES = 16,
  parameter int DW        = 32,
  parameter int AW        = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic [NUM_CH-1:0] irq_i,
  output logic [NUM_CH-1:0] irq_clean_o,
  output logic              irq_o
);
  logic [NUM_CH-1:0] clean, rise, pend, pend_nxt, enable, mode, eff;
  logic [NUM_CH-1:0] wmask, wbits, en_nxt, mode_nxt;
  logic              gen;
  logic [2:0]        ofs;
  logic              req, mapped, hit, wr;
  logic [DW-1:0]     bmask, rdata;
  logic              unused_adr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    wb_irq_debounce_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .raw   (irq_i[i]),
      .clean (clean[i]),
      .rise  (rise[i])
    );
  end

  assign irq_clean_o = clean;
  assign wb_rty_o    = 1'b0;
  assign unused_adr  = ^{wb_adr_i[AW-1:5], wb_adr_i[1:0]};

  // level channels report the live clean state, edge channels the latch
  assign eff = (mode & pend) | (~mode & clean);

  assign ofs    = wb_adr_i[4:2];
  assign req    = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o;
  assign mapped = (ofs <= 3'd4);
  assign hit    = req & mapped;
  assign wr     = hit & wb_we_i;

  assign bmask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask    = NUM_CH'(bmask);
  assign wbits    = NUM_CH'(wb_dat_i & bmask);
  assign en_nxt   = (enable & ~wmask) | wbits;
  assign mode_nxt = (mode & ~wmask) | wbits;

  always_comb begin
    pend_nxt = pend;
    if (wr && ofs == 3'd3) pend_nxt = pend_nxt & ~(mode ^ mode_nxt);
    if (wr && ofs == 3'd1) pend_nxt = pend_nxt & ~(wbits & mode);
    // a fresh rising edge beats a same-cycle clear
    pend_nxt = pend_nxt | (rise & mode);
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      3'd0:    rdata = DW'(clean);
      3'd1:    rdata = DW'(eff);
      3'd2:    rdata = DW'(enable);
      3'd3:    rdata = DW'(mode);
      3'd4:    rdata = DW'(gen);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      pend     <= '0;
      enable   <= '0;
      mode     <= '0;
      gen      <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= hit;
      wb_err_o <= req & ~mapped;
      wb_dat_o <= (hit && !wb_we_i) ? rdata : '0;
      pend     <= pend_nxt;
      if (wr && ofs == 3'd2) enable <= en_nxt;
      if (wr && ofs == 3'd3) mode   <= mode_nxt;
      if (wr && ofs == 3'd4 && wb_sel_i[0]) gen <= wb_dat_i[0];
      irq_o <= gen & |(eff & enable);
    end
  end
endmodule

// File: tb/tb_wb_irq_debounce_ctrl.sv
// Directed bench for wb_irq_debounce_ctrl: register table plus timed sequences
// for debounce latency, edge/level pending, masking and reset.

module tb_wb_irq_debounce_ctrl;
  localparam int NUM_CH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       adr = '0;
  logic [31:0]       wdat = '0;
  logic [31:0]       rdat;
  logic [3:0]        sel = '0;
  logic              we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic              ack, err, rty;
  logic [NUM_CH-1:0] irq = '0;
  logic [NUM_CH-1:0] clean;
  logic              irq_out;

  int total = 0;
  int pass  = 0;

  wb_irq_debounce_ctrl #(.NUM_CH(NUM_CH), .DB_CYCLES(16), .DW(32), .AW(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rdat), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .irq_i(irq), .irq_clean_o(clean), .irq_o(irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // called #1 after an edge; returns #1 after the edge that responded
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic ra, output logic re,
                     output logic [31:0] rd);
    int n = 0;
    we = w; adr = {24'h0, a}; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!(ack || err) && n < 8);
    ra = ack; re = err; rd = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!(ra || re)) chk("bus_timeout", 32'(ra | re), 32'd1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic ra, re; logic [31:0] rd;
    bus(1'b1, a, d, 4'hF, ra, re, rd);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic ra, re; logic [31:0] rd;
    bus(1'b0, a, 32'h0, 4'hF, ra, re, rd);
    chk(nm, rd, exp);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic ra, re;
    logic [31:0] rd;
    int acks;
    logic ch1_bad;

    tbl[0]  = '{1'b0, 8'h00, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 8'h0C, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 8'h10, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, 32'h0000_00FF};
    tbl[7]  = '{1'b1, 8'h08, 32'h0,         4'h2, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, 32'h0000_00FF};
    tbl[9]  = '{1'b1, 8'h0C, 32'h0000_00A5, 4'hF, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 8'h0C, 32'h0,         4'hF, 1'b0, 32'h0000_00A5};
    tbl[11] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 8'h10, 32'h0,         4'hF, 1'b0, 32'h1};
    tbl[13] = '{1'b0, 8'h14, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 8'h14, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 8'h1C, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[16] = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, 32'h0000_00FF};
    tbl[17] = '{1'b1, 8'h0C, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[18] = '{1'b1, 8'h08, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[19] = '{1'b1, 8'h10, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 8'h10, 32'h0,         4'hF, 1'b0, 32'h0};

    // reset dropped mid-operation
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    wr(8'h10, 32'h1); wr(8'h08, 32'hFF);
    irq[0] = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    chk("pre_reset_irq", 32'(irq_out), 32'd1);
    we = 1'b0; adr = 32'h0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_ack", {30'd0, ack, rdat[0]}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {22'd0, clean, irq_out, ack, err, rty}, 32'h0);
    chk("reset_dat", rdat, 32'h0);
    stb = 1'b0; cyc = 1'b0; irq = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // register map table
    for (int i = 0; i < 21; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, ra, re, rd);
      chk($sformatf("tbl%0d_ack", i), 32'(ra), 32'(!tbl[i].eerr));
      chk($sformatf("tbl%0d_err", i), 32'(re), 32'(tbl[i].eerr));
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].erd);
    end
    @(posedge clk); #1;
    chk("err_one_cycle", {30'd0, ack, err}, 32'h0);

    // held strobe answers every other cycle
    we = 1'b0; adr = 32'h0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("held_stb_acks", 32'(acks), 32'd3);
    @(posedge clk); #1;

    // debounce latency, glitch rejection, edge-mode irq
    wr(8'h0C, 32'h1); wr(8'h08, 32'h1); wr(8'h10, 32'h1);
    @(posedge clk); #1;
    irq[0] = 1'b1; irq[1] = 1'b1;
    ch1_bad = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (clean[1]) ch1_bad = 1'b1;
      if (k == 15) irq[1] = 1'b0;
      if (k == 17) chk("clean0_e17", 32'(clean[0]), 32'd0);
      if (k == 18) chk("clean0_e18", 32'(clean[0]), 32'd1);
      if (k == 18) chk("irq_e18", 32'(irq_out), 32'd0);
      if (k == 19) chk("irq_e19", 32'(irq_out), 32'd1);
      if (k == 20) irq[0] = 1'b0;
    end
    chk("ch1_glitch", 32'(ch1_bad), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("clean0_fell", 32'(clean[0]), 32'd0);
    chk("pend_kept_irq", 32'(irq_out), 32'd1);
    rd_chk("pend_kept", 8'h04, 32'h1);

    // W1C drops irq one edge after ack
    wr(8'h04, 32'h1);
    chk("w1c_irq_at_ack", 32'(irq_out), 32'd1);
    @(posedge clk); #1;
    chk("w1c_irq_after", 32'(irq_out), 32'd0);

    // W1C landing on the same edge as a new rise
    irq[0] = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    we = 1'b1; adr = 32'h4; wdat = 32'h1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    chk("race_ack_clean", {30'd0, ack, clean[0]}, 32'h3);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("race_irq", 32'(irq_out), 32'd1);
    rd_chk("race_pend", 8'h04, 32'h1);

    // level mode and masking
    irq[0] = 1'b0;
    wr(8'h08, 32'h4); wr(8'h0C, 32'h0);
    irq[2] = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    chk("level_irq", 32'(irq_out), 32'd1);
    rd_chk("level_pend", 8'h04, 32'h4);
    wr(8'h08, 32'h0);
    @(posedge clk); #1;
    chk("mask_irq", 32'(irq_out), 32'd0);
    wr(8'h04, 32'h4);
    rd_chk("level_w1c_noeff", 8'h04, 32'h4);

    // mode change clears the latch
    wr(8'h0C, 32'h8);
    irq[3] = 1'b1;
    repeat (22) @(posedge clk);
    #1;
    rd_chk("edge3_pend", 8'h04, 32'hC);
    wr(8'h0C, 32'h0);
    rd_chk("mode_level_pend", 8'h04, 32'hC);
    wr(8'h0C, 32'h8);
    rd_chk("mode_edge_cleared", 8'h04, 32'h4);
    rd_chk("status_final", 8'h00, 32'hC);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
